// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: round-robin sequencer feeding one shared ALU from two requesters.
// An accepted op is held on alu_ctrl for HOLD_CYCLES cycles so the flags settle with the
// result, captured for one cycle with ACC/MR write enables, then returned as a tagged response.
module alu_op_sequencer #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [3:0]        req0_op,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [3:0]        req1_op,
    output logic              req1_ready,
    output logic [15:0]       alu_ctrl,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] alu_mr,
    input  logic [3:0]        alu_flags,
    output logic              acc_we,
    output logic              mr_we,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_data,
    output logic [3:0]        rsp_flags,
    output logic              busy
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StIssue   = 2'd1;
    localparam logic [1:0] StCapture = 2'd2;
    localparam logic [1:0] StResp    = 2'd3;

    localparam logic [2:0] HoldLast = 3'(HOLD_CYCLES - 1);

    logic [1:0]        state_q;
    logic              last_grant_q;
    logic [3:0]        op_q;
    logic [2:0]        cnt_q;
    logic              rsp_id_q;
    logic              rsp_err_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic [3:0]        rsp_flags_q;

    logic       grant;
    logic       accept;
    logic [3:0] sel_op;
    logic       sel_legal;

    // Arbitration: a lone requester wins; on contention the one not served last time wins.
    always_comb begin
        grant      = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
        req0_ready = (state_q == StIdle) && req0_valid && !grant;
        req1_ready = (state_q == StIdle) && req1_valid && grant;
        accept     = req0_ready || req1_ready;
        sel_op     = grant ? req1_op : req0_op;
        sel_legal  = (sel_op >= 4'd1) && (sel_op <= 4'd9);
    end

    // Sequencing FSM, op/id latch and response capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            op_q         <= 4'd0;
            cnt_q        <= 3'd0;
            rsp_id_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_data_q   <= '0;
            rsp_flags_q  <= 4'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        last_grant_q <= grant;
                        op_q         <= sel_op;
                        cnt_q        <= 3'd0;
                        rsp_id_q     <= grant;
                        if (sel_legal) begin
                            state_q <= StIssue;
                        end else begin
                            // Illegal opcode never reaches the ALU; answer with an error at once.
                            state_q     <= StResp;
                            rsp_err_q   <= 1'b1;
                            rsp_data_q  <= '0;
                            rsp_flags_q <= 4'd0;
                        end
                    end
                end
                StIssue: begin
                    if (cnt_q == HoldLast) begin
                        state_q <= StCapture;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                StCapture: begin
                    rsp_err_q   <= 1'b0;
                    rsp_data_q  <= alu_result;
                    rsp_flags_q <= alu_flags;
                    state_q     <= StResp;
                end
                StResp: begin
                    if (rsp_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Outputs decoded from state; alu_mr is consumed by the MR register, not by this block.
    always_comb begin
        alu_ctrl  = (state_q == StIssue) ? {op_q, 12'h000} : 16'h0000;
        acc_we    = (state_q == StCapture);
        mr_we     = (state_q == StCapture) && alu_flags[3];
        rsp_valid = (state_q == StResp);
        busy      = (state_q != StIdle);
        rsp_id    = rsp_id_q;
        rsp_err   = rsp_err_q;
        rsp_data  = rsp_data_q;
        rsp_flags = rsp_flags_q;
    end

    logic unused_mr;
    assign unused_mr = ^alu_mr;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed scenarios plus a randomized run, checked against a
// transaction-level model (expected grant, timeline and response per op).
module tb_alu_op_sequencer;

    localparam int HOLD = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [3:0]  req0_op, req1_op;
    logic        req0_ready, req1_ready;
    logic [15:0] alu_ctrl;
    logic [15:0] alu_result, alu_mr;
    logic [3:0]  alu_flags;
    logic        acc_we, mr_we, rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
    logic [15:0] rsp_data;
    logic [3:0]  rsp_flags;

    int total = 0;
    int bad   = 0;
    logic        last_m;      // model of last granted requester
    logic [15:0] opa, opb;    // ALU operands supplied by the bench
    logic [3:0]  prev_op;

    always #5 clk = ~clk;

    alu_op_sequencer #(.DATA_W(16), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_ready(req1_ready),
        .alu_ctrl(alu_ctrl), .alu_result(alu_result), .alu_mr(alu_mr), .alu_flags(alu_flags),
        .acc_we(acc_we), .mr_we(mr_we),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_err(rsp_err),
        .rsp_data(rsp_data), .rsp_flags(rsp_flags), .busy(busy)
    );

    // Reference ALU: returns {flags, mr, result}.
    function automatic logic [35:0] alu_f(input logic [3:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
        logic [15:0] r, m;
        logic [31:0] p;
        logic ovf, mren;
        r = 16'h0; m = 16'h0; ovf = 1'b0; mren = 1'b0;
        case (op)
            4'd1: r = 16'h0;
            4'd2: begin r = a + b; ovf = (a[15] == b[15]) && (r[15] != a[15]); end
            4'd3: begin r = a - b; ovf = (a[15] != b[15]) && (r[15] != a[15]); end
            4'd4: begin p = a * b; r = p[15:0]; m = p[31:16]; mren = 1'b1; end
            4'd5: r = a & b;
            4'd6: r = a | b;
            4'd7: r = ~a;
            4'd8: r = a << 1;
            4'd9: r = a >> 1;
            default: r = 16'h0;
        endcase
        return {mren, ovf, (r == 16'h0), r[15], m, r};
    endfunction

    // ALU stand-in: result is only valid once the opcode has been seen on two successive
    // edges; the first edge yields garbage, exposing any short hold or early capture.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_result <= 16'h0; alu_mr <= 16'h0; alu_flags <= 4'h0; prev_op <= 4'h0;
        end else begin
            prev_op <= alu_ctrl[15:12];
            if (alu_ctrl[15:12] != 4'h0) begin
                if (prev_op == alu_ctrl[15:12])
                    {alu_flags, alu_mr, alu_result} <= alu_f(alu_ctrl[15:12], opa, opb);
                else begin
                    alu_result <= 16'hDEAD; alu_mr <= 16'hBEEF; alu_flags <= 4'h0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ".alu_ctrl"}, 32'(alu_ctrl), 32'h0);
        chk({tag, ".we"}, {30'h0, acc_we, mr_we}, 32'h0);
        chk({tag, ".rsp"}, {rsp_valid, rsp_id, rsp_err, rsp_flags, 9'h0, rsp_data}, 32'h0);
        chk({tag, ".busy"}, 32'(busy), 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        #1 chk_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        last_m = 1'b1;
    endtask

    // One full transaction: present valids, check grant, follow the op through the DUT.
    task automatic run_txn(input logic v0, input logic v1, input logic [3:0] op0,
                           input logic [3:0] op1, input logic [15:0] a, input logic [15:0] b,
                           input int stall);
        logic        g;
        logic [3:0]  op;
        logic        legal;
        logic [35:0] exp;
        @(negedge clk);
        opa = a; opb = b;
        req0_valid = v0; req1_valid = v1; req0_op = op0; req1_op = op1;
        g = (v0 && v1) ? ~last_m : v1;
        op = g ? op1 : op0;
        legal = (op >= 4'd1) && (op <= 4'd9);
        exp = legal ? alu_f(op, a, b) : 36'h0;
        #1;
        chk("grant.ready", {30'h0, req1_ready, req0_ready}, {30'h0, g, ~g});
        chk("grant.busy", 32'(busy), 32'h0);
        @(posedge clk);
        last_m = g;
        @(negedge clk);
        // Opcode change after acceptance must not matter.
        req0_op = ~op0; req1_op = ~op1;
        if (legal) begin
            for (int k = 0; k < HOLD; k++) begin
                #1;
                chk("issue.ctrl", 32'(alu_ctrl), {16'h0, op, 12'h000});
                chk("issue.we", {30'h0, acc_we, mr_we}, 32'h0);
                chk("issue.state", {29'h0, busy, rsp_valid, req0_ready | req1_ready}, 32'h4);
                @(negedge clk);
            end
            #1;
            chk("capture.ctrl", 32'(alu_ctrl), 32'h0);
            chk("capture.we", {30'h0, acc_we, mr_we}, {30'h0, 1'b1, exp[35]});
            chk("capture.rspv", 32'(rsp_valid), 32'h0);
            @(negedge clk);
        end
        for (int s = 0; s <= stall; s++) begin
            rsp_ready = (s == stall);
            #1;
            chk("resp.valid", {30'h0, rsp_valid, busy}, 32'h3);
            chk("resp.tag", {30'h0, rsp_id, rsp_err}, {30'h0, g, ~legal});
            chk("resp.data", {12'h0, rsp_flags, rsp_data}, {12'h0, exp[35:32], exp[15:0]});
            chk("resp.quiet", {13'h0, req0_ready, req1_ready, alu_ctrl, acc_we, mr_we}, 32'h0);
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        #1 chk("done.idle", {30'h0, rsp_valid, busy}, 32'h0);
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        req0_op = 4'h0; req1_op = 4'h0; rsp_ready = 1'b0; opa = 16'h0; opb = 16'h0;
        last_m = 1'b1;
        #1 chk_idle_outputs("por");
        do_reset();

        // T1: ADD 3+4 from requester 0.
        run_txn(1'b1, 1'b0, 4'd2, 4'd0, 16'h0003, 16'h0004, 0);

        // T2: contention, NOT from both, 4 ops each; grants must alternate.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            run_txn(1'b1, 1'b1, 4'd7, 4'd7, 16'(i * 16'h1111), 16'h0, 0);
            chk("t2.order", 32'(last_m), 32'(i % 2));
        end

        // T3: MPY 0x100*0x100 from requester 1 -> MR write.
        run_txn(1'b0, 1'b1, 4'd0, 4'd4, 16'h0100, 16'h0100, 0);

        // T4: illegal opcode 0xC.
        run_txn(1'b1, 1'b0, 4'hC, 4'd0, 16'h1234, 16'h5678, 0);

        // T5: response stalled 5 cycles, other requester waiting.
        run_txn(1'b1, 1'b1, 4'd3, 4'd5, 16'h8000, 16'h0001, 5);

        // T6: reset in the middle of ISSUE drops the op.
        @(negedge clk);
        opa = 16'h0001; opb = 16'h0001;
        req0_valid = 1'b1; req0_op = 4'd2; req1_valid = 1'b0;
        @(negedge clk);
        #1 chk("t6.issue", 32'(alu_ctrl), 32'h2000);
        rst_n = 1'b0; req0_valid = 1'b0;
        #1 chk_idle_outputs("t6.rst");
        @(negedge clk);
        rst_n = 1'b1; last_m = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 chk("t6.norsp", {30'h0, rsp_valid, busy}, 32'h0);
        end
        run_txn(1'b1, 1'b0, 4'd6, 4'd0, 16'h00F0, 16'h0F00, 0);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            logic v0, v1;
            logic [3:0] o0, o1;
            v0 = 1'($urandom_range(0, 1));
            v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
            o0 = ($urandom_range(0, 6) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(1, 9));
            o1 = ($urandom_range(0, 6) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 9));
            run_txn(v0, v1, o0, o1, 16'($urandom), 16'($urandom), int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
